ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
EX/MEM pipeline register of the 32-bit MIPS datapath. It sits directly downstream of the ALU and captures the ALU result and zero flag, the store data, the destination register and the MEM/WB control bits at each clock edge. It resolves conditional branches from the captured zero flag. It also supplies forwarding information to the EX-stage operand muxes, and supports stall (hold) and flush (bubble insertion).

Parameters:
DATA_W, 32, width of ALU result, store data and PC values
REG_ADDR_W, 5, width of register-file addresses

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hold all registered contents this cycle
flush  input  1  load a bubble this cycle
in_valid  input  1  EX stage holds a real instruction
resultado_in  input  DATA_W  ALU result
zeroFlag_in  input  1  ALU zero flag
rtData_in  input  DATA_W  store data (rt operand after forwarding)
regDest_in  input  REG_ADDR_W  destination register
regWrite_in, memRead_in, memWrite_in, memToReg_in, branch_in  input  1 each  control bits from ID/EX
branchTarget_in  input  DATA_W  computed branch target
valid_out  output  1  MEM stage holds a real instruction
resultado_out  output  DATA_W  registered ALU result (memory address or writeback value)
zeroFlag_out  output  1  registered zero flag
rtData_out  output  DATA_W  registered store data
regDest_out  output  REG_ADDR_W  registered destination
regWrite_out, memRead_out, memWrite_out, memToReg_out  output  1 each  registered control
branchTaken  output  1  branch_out & zeroFlag_out & valid_out
branchTarget_out  output  DATA_W  registered branch target
fwdValid  output  1  valid_out & regWrite_out & (regDest_out != 0)
fwdData  output  DATA_W  equals resultado_out

Behaviour:
- Reset: synchronous; on a rising edge with rst=1, every registered output is cleared to 0. This gives valid_out=0, branchTaken=0 and fwdValid=0. rst overrides flush and stall.
- Priority per edge: rst > flush > stall > load.
- Flush:
  - valid_out and all control registers (regWrite, memRead, memWrite, memToReg, branch) go to 0.
  - Data registers (resultado, zeroFlag, rtData, regDest, branchTarget) go to 0, so a bubble is fully deterministic.
- Stall (flush=0): every register keeps its value. Outputs are unchanged for the whole stalled cycle(s).
- Load (rst=flush=stall=0):
  - All *_in values are captured. valid_out <= in_valid.
  - If in_valid=0, control registers are loaded as 0 regardless of their inputs. A non-valid instruction must never write memory or the register file.
- Latency: exactly one cycle from input to output; no combinational path from *_in to any output.
- branchTaken, fwdValid and fwdData are pure combinational functions of the registered state, stable for the full cycle.
- fwdValid is 0 whenever regDest_out = 0, because $zero is never forwarded.
- memRead_out and memWrite_out are both loaded as given; mutual exclusion is guaranteed by decode and is not checked here.
- Width rules:
  - Data are passed bit-exact; no sign or zero extension is done in this block.
  - zeroFlag_out is taken from zeroFlag_in and is not recomputed from resultado.
- Simultaneous flush and stall: flush wins and a bubble is loaded.
- Reset asserted mid-stall: state clears on that edge and the stall is ignored.

Test Plan:
1. rst=1 for 2 edges with arbitrary inputs -> all outputs 0, branchTaken=0, fwdValid=0.
2. Load in_valid=1, resultado_in=0x0000_00A5, regDest_in=8, regWrite_in=1 -> next cycle resultado_out=0xA5, regDest_out=8, fwdValid=1, fwdData=0xA5. Then regDest_in=0 with the same controls -> fwdValid=0.
3. Load branch_in=1, zeroFlag_in=1, branchTarget_in=0x0040_0020, in_valid=1 -> branchTaken=1, branchTarget_out=0x0040_0020. Same with zeroFlag_in=0 -> branchTaken=0.
4. Load a valid instruction (resultado 0x1234), then stall=1 for 3 cycles while the inputs change -> outputs hold 0x1234 and the original controls for all 3 cycles. Deassert stall -> the new inputs appear one cycle later.
5. flush=1 and stall=1 together with valid memWrite_in=1 inputs -> next cycle valid_out=0, memWrite_out=0, resultado_out=0.
6. in_valid=0 with regWrite_in=1, memWrite_in=1 -> regWrite_out=0, memWrite_out=0, fwdValid=0. resultado_out still captures resultado_in.

Source files
------------

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register for the 32-bit MIPS datapath.
//
// Captures the ALU result, the zero flag, the store data, the destination
// register, the branch target and the MEM/WB control bits on every rising
// edge. Each edge does exactly one of the following, in priority order:
// reset, flush (load a bubble), stall (hold), or load.
// It also resolves a conditional branch from the captured zero flag, and
// provides forwarding information for the EX-stage operand muxes.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   stall, flush        hold all contents / load an all-zero bubble
//   in_valid            EX stage holds a real instruction
//   *_in                ALU result, zero flag, store data, destination,
//                       control bits and branch target from EX
//   valid_out, *_out    registered copies of the above
//   branchTaken         registered branch & zero flag & valid
//   fwdValid, fwdData   forwarding of the MEM-stage result (never for $zero)
module ex_mem_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     resultado_in,
  input  logic                  zeroFlag_in,
  input  logic [DATA_W-1:0]     rtData_in,
  input  logic [REG_ADDR_W-1:0] regDest_in,
  input  logic                  regWrite_in,
  input  logic                  memRead_in,
  input  logic                  memWrite_in,
  input  logic                  memToReg_in,
  input  logic                  branch_in,
  input  logic [DATA_W-1:0]     branchTarget_in,
  output logic                  valid_out,
  output logic [DATA_W-1:0]     resultado_out,
  output logic                  zeroFlag_out,
  output logic [DATA_W-1:0]     rtData_out,
  output logic [REG_ADDR_W-1:0] regDest_out,
  output logic                  regWrite_out,
  output logic                  memRead_out,
  output logic                  memWrite_out,
  output logic                  memToReg_out,
  output logic                  branchTaken,
  output logic [DATA_W-1:0]     branchTarget_out,
  output logic                  fwdValid,
  output logic [DATA_W-1:0]     fwdData
);

  logic                  valid_q,    valid_d;
  logic [DATA_W-1:0]     res_q,      res_d;
  logic                  zero_q,     zero_d;
  logic [DATA_W-1:0]     rt_q,       rt_d;
  logic [REG_ADDR_W-1:0] dest_q,     dest_d;
  logic                  regwrite_q, regwrite_d;
  logic                  memread_q,  memread_d;
  logic                  memwrite_q, memwrite_d;
  logic                  memtoreg_q, memtoreg_d;
  logic                  branch_q,   branch_d;
  logic [DATA_W-1:0]     target_q,   target_d;

  always_comb begin
    // By default every register holds its value; this is also the stall case.
    valid_d    = valid_q;
    res_d      = res_q;
    zero_d     = zero_q;
    rt_d       = rt_q;
    dest_d     = dest_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    memtoreg_d = memtoreg_q;
    branch_d   = branch_q;
    target_d   = target_q;

    if (flush) begin
      // The bubble is fully zero, data included, so that it is deterministic.
      valid_d    = 1'b0;
      res_d      = '0;
      zero_d     = 1'b0;
      rt_d       = '0;
      dest_d     = '0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      branch_d   = 1'b0;
      target_d   = '0;
    end else if (!stall) begin
      valid_d    = in_valid;
      res_d      = resultado_in;
      zero_d     = zeroFlag_in;
      rt_d       = rtData_in;
      dest_d     = regDest_in;
      // Control bits are gated by in_valid. A non-valid slot must never
      // write memory or the register file.
      regwrite_d = regWrite_in & in_valid;
      memread_d  = memRead_in  & in_valid;
      memwrite_d = memWrite_in & in_valid;
      memtoreg_d = memToReg_in & in_valid;
      branch_d   = branch_in   & in_valid;
      target_d   = branchTarget_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      rt_q       <= '0;
      dest_q     <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      branch_q   <= 1'b0;
      target_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
      rt_q       <= rt_d;
      dest_q     <= dest_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      branch_q   <= branch_d;
      target_q   <= target_d;
    end
  end

  assign valid_out        = valid_q;
  assign resultado_out    = res_q;
  assign zeroFlag_out     = zero_q;
  assign rtData_out       = rt_q;
  assign regDest_out      = dest_q;
  assign regWrite_out     = regwrite_q;
  assign memRead_out      = memread_q;
  assign memWrite_out     = memwrite_q;
  assign memToReg_out     = memtoreg_q;
  assign branchTarget_out = target_q;

  assign branchTaken = branch_q & zero_q & valid_q;
  // $zero is hard-wired, so a write to it is never forwarded.
  assign fwdValid    = valid_q & regwrite_q & (dest_q != '0);
  assign fwdData     = res_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid;
  logic [31:0] resultado_in, rtData_in, branchTarget_in;
  logic        zeroFlag_in;
  logic [4:0]  regDest_in;
  logic        regWrite_in, memRead_in, memWrite_in, memToReg_in, branch_in;
  logic        valid_out, zeroFlag_out;
  logic [31:0] resultado_out, rtData_out, branchTarget_out, fwdData;
  logic [4:0]  regDest_out;
  logic        regWrite_out, memRead_out, memWrite_out, memToReg_out;
  logic        branchTaken, fwdValid;

  int checks = 0;
  int errors = 0;

  ex_mem_reg #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .resultado_in(resultado_in), .zeroFlag_in(zeroFlag_in), .rtData_in(rtData_in),
    .regDest_in(regDest_in), .regWrite_in(regWrite_in), .memRead_in(memRead_in),
    .memWrite_in(memWrite_in), .memToReg_in(memToReg_in), .branch_in(branch_in),
    .branchTarget_in(branchTarget_in),
    .valid_out(valid_out), .resultado_out(resultado_out), .zeroFlag_out(zeroFlag_out),
    .rtData_out(rtData_out), .regDest_out(regDest_out), .regWrite_out(regWrite_out),
    .memRead_out(memRead_out), .memWrite_out(memWrite_out), .memToReg_out(memToReg_out),
    .branchTaken(branchTaken), .branchTarget_out(branchTarget_out),
    .fwdValid(fwdValid), .fwdData(fwdData)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] res, input logic zf,
                        input logic [31:0] rt, input logic [4:0] dest,
                        input logic rw, input logic mr, input logic mw,
                        input logic mtr, input logic br, input logic [31:0] tgt);
    in_valid = v; resultado_in = res; zeroFlag_in = zf; rtData_in = rt;
    regDest_in = dest; regWrite_in = rw; memRead_in = mr; memWrite_in = mw;
    memToReg_in = mtr; branch_in = br; branchTarget_in = tgt;
  endtask

  task automatic test_reset();
    set_in(1'b1, 32'hFFFF_FFFF, 1'b1, 32'h1357_9BDF, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hABCD_EF01);
    rst = 1'b1; stall = 1'b1; flush = 1'b0;
    tick(); tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", valid_out); end
    checks++; if (resultado_out !== 32'h0) begin errors++; $display("FAIL rst_res: got %h exp 0", resultado_out); end
    checks++; if (zeroFlag_out !== 1'b0) begin errors++; $display("FAIL rst_zero: got %b exp 0", zeroFlag_out); end
    checks++; if (rtData_out !== 32'h0) begin errors++; $display("FAIL rst_rt: got %h exp 0", rtData_out); end
    checks++; if (regDest_out !== 5'd0) begin errors++; $display("FAIL rst_dest: got %0d exp 0", regDest_out); end
    checks++; if ({regWrite_out, memRead_out, memWrite_out, memToReg_out} !== 4'b0000)
      begin errors++; $display("FAIL rst_ctl: got %b exp 0000", {regWrite_out, memRead_out, memWrite_out, memToReg_out}); end
    checks++; if (branchTarget_out !== 32'h0) begin errors++; $display("FAIL rst_tgt: got %h exp 0", branchTarget_out); end
    checks++; if (branchTaken !== 1'b0) begin errors++; $display("FAIL rst_btaken: got %b exp 0", branchTaken); end
    checks++; if (fwdValid !== 1'b0) begin errors++; $display("FAIL rst_fwdvalid: got %b exp 0", fwdValid); end
    checks++; if (fwdData !== 32'h0) begin errors++; $display("FAIL rst_fwddata: got %h exp 0", fwdData); end
    rst = 1'b0; stall = 1'b0;
  endtask

  task automatic test_forward();
    set_in(1'b1, 32'h0000_00A5, 1'b0, 32'hDEAD_BEEF, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL fwd_valid: got %b exp 1", valid_out); end
    checks++; if (resultado_out !== 32'h0000_00A5) begin errors++; $display("FAIL fwd_res: got %h exp 000000a5", resultado_out); end
    checks++; if (regDest_out !== 5'd8) begin errors++; $display("FAIL fwd_dest: got %0d exp 8", regDest_out); end
    checks++; if (rtData_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fwd_rt: got %h exp deadbeef", rtData_out); end
    checks++; if (regWrite_out !== 1'b1) begin errors++; $display("FAIL fwd_rw: got %b exp 1", regWrite_out); end
    checks++; if (fwdValid !== 1'b1) begin errors++; $display("FAIL fwd_fwdvalid: got %b exp 1", fwdValid); end
    checks++; if (fwdData !== 32'h0000_00A5) begin errors++; $display("FAIL fwd_fwddata: got %h exp 000000a5", fwdData); end
    // Same controls, destination $zero; the data pattern checks bit-exact capture.
    set_in(1'b1, 32'h8000_0001, 1'b0, 32'h0000_0000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checks++; if (fwdValid !== 1'b0) begin errors++; $display("FAIL fwd_zero_dest: got %b exp 0", fwdValid); end
    checks++; if (regWrite_out !== 1'b1) begin errors++; $display("FAIL fwd_zero_rw: got %b exp 1", regWrite_out); end
    checks++; if (fwdData !== 32'h8000_0001) begin errors++; $display("FAIL fwd_bitexact: got %h exp 80000001", fwdData); end
    // Destination 1 is the lowest forwardable register.
    regDest_in = 5'd1;
    tick();
    checks++; if (fwdValid !== 1'b1) begin errors++; $display("FAIL fwd_dest1: got %b exp 1", fwdValid); end
  endtask

  task automatic test_branch();
    // A non-zero result with zero flag 1 shows the flag is not recomputed.
    set_in(1'b1, 32'h0000_0005, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0020);
    tick();
    checks++; if (branchTaken !== 1'b1) begin errors++; $display("FAIL br_taken: got %b exp 1", branchTaken); end
    checks++; if (branchTarget_out !== 32'h0040_0020) begin errors++; $display("FAIL br_tgt: got %h exp 00400020", branchTarget_out); end
    checks++; if (zeroFlag_out !== 1'b1) begin errors++; $display("FAIL br_zero: got %b exp 1", zeroFlag_out); end
    set_in(1'b1, 32'h0000_0000, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0040);
    tick();
    checks++; if (branchTaken !== 1'b0) begin errors++; $display("FAIL br_nottaken: got %b exp 0", branchTaken); end
    checks++; if (zeroFlag_out !== 1'b0) begin errors++; $display("FAIL br_zero0: got %b exp 0", zeroFlag_out); end
    // A branch in a non-valid slot must not be taken.
    set_in(1'b0, 32'h0000_0000, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0060);
    tick();
    checks++; if (branchTaken !== 1'b0) begin errors++; $display("FAIL br_invalid: got %b exp 0", branchTaken); end
    checks++; if (branchTarget_out !== 32'h0040_0060) begin errors++; $display("FAIL br_invalid_tgt: got %h exp 00400060", branchTarget_out); end
  endtask

  task automatic test_stall();
    set_in(1'b1, 32'h0000_1234, 1'b0, 32'h0000_00EE, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h5555_0000 + i, 1'b1, 32'h1111_1111, 5'd3 + 5'(i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h9999_0000);
      #1;
      checks++; if (resultado_out !== 32'h0000_1234) begin errors++; $display("FAIL stall_comb_%0d: got %h exp 00001234", i, resultado_out); end
      tick();
      checks++; if (resultado_out !== 32'h0000_1234) begin errors++; $display("FAIL stall_res_%0d: got %h exp 00001234", i, resultado_out); end
      checks++; if ({valid_out, regWrite_out, memRead_out, memWrite_out, memToReg_out, regDest_out} !== {5'b11001, 5'd9})
        begin errors++; $display("FAIL stall_ctl_%0d: got %b exp 1100101001", i, {valid_out, regWrite_out, memRead_out, memWrite_out, memToReg_out, regDest_out}); end
      checks++; if (branchTaken !== 1'b0) begin errors++; $display("FAIL stall_btaken_%0d: got %b exp 0", i, branchTaken); end
    end
    stall = 1'b0;
    tick();
    checks++; if (resultado_out !== 32'h5555_0002) begin errors++; $display("FAIL unstall_res: got %h exp 55550002", resultado_out); end
    checks++; if ({regWrite_out, memRead_out, memWrite_out, regDest_out} !== {3'b011, 5'd5})
      begin errors++; $display("FAIL unstall_ctl: got %b exp 01100101", {regWrite_out, memRead_out, memWrite_out, regDest_out}); end
    checks++; if (branchTaken !== 1'b1) begin errors++; $display("FAIL unstall_btaken: got %b exp 1", branchTaken); end
  endtask

  task automatic test_flush_stall();
    set_in(1'b1, 32'h0000_CAFE, 1'b1, 32'h0BAD_F00D, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_4444);
    flush = 1'b1; stall = 1'b1;
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", valid_out); end
    checks++; if (memWrite_out !== 1'b0) begin errors++; $display("FAIL flush_mw: got %b exp 0", memWrite_out); end
    checks++; if (resultado_out !== 32'h0) begin errors++; $display("FAIL flush_res: got %h exp 0", resultado_out); end
    checks++; if ({rtData_out, branchTarget_out, regDest_out, zeroFlag_out} !== 70'h0)
      begin errors++; $display("FAIL flush_data: got %h exp 0", {rtData_out, branchTarget_out, regDest_out, zeroFlag_out}); end
    checks++; if ({regWrite_out, memRead_out, memToReg_out, branchTaken} !== 4'b0000)
      begin errors++; $display("FAIL flush_ctl: got %b exp 0000", {regWrite_out, memRead_out, memToReg_out, branchTaken}); end
    flush = 1'b0; stall = 1'b0;
    tick();
    checks++; if (resultado_out !== 32'h0000_CAFE || memWrite_out !== 1'b1)
      begin errors++; $display("FAIL post_flush_load: got %h/%b exp 0000cafe/1", resultado_out, memWrite_out); end
  endtask

  task automatic test_invalid();
    set_in(1'b0, 32'h0000_0077, 1'b0, 32'h0000_0088, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checks++; if (regWrite_out !== 1'b0) begin errors++; $display("FAIL inv_rw: got %b exp 0", regWrite_out); end
    checks++; if (memWrite_out !== 1'b0) begin errors++; $display("FAIL inv_mw: got %b exp 0", memWrite_out); end
    checks++; if ({memRead_out, memToReg_out, valid_out} !== 3'b000)
      begin errors++; $display("FAIL inv_ctl: got %b exp 000", {memRead_out, memToReg_out, valid_out}); end
    checks++; if (fwdValid !== 1'b0) begin errors++; $display("FAIL inv_fwd: got %b exp 0", fwdValid); end
    checks++; if (resultado_out !== 32'h0000_0077) begin errors++; $display("FAIL inv_res: got %h exp 00000077", resultado_out); end
    checks++; if (regDest_out !== 5'd5) begin errors++; $display("FAIL inv_dest: got %0d exp 5", regDest_out); end
  endtask

  task automatic test_reset_mid_stall();
    set_in(1'b1, 32'h0000_0042, 1'b1, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    tick();
    stall = 1'b1; rst = 1'b1;
    tick();
    checks++; if ({valid_out, resultado_out, regDest_out, regWrite_out, branchTaken, fwdValid} !== 41'h0)
      begin errors++; $display("FAIL rst_stall: got %h exp 0", {valid_out, resultado_out, regDest_out, regWrite_out, branchTaken, fwdValid}); end
    rst = 1'b0;
    tick();
    checks++; if ({valid_out, resultado_out} !== 33'h0)
      begin errors++; $display("FAIL rst_then_stall: got %h exp 0", {valid_out, resultado_out}); end
    stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_forward();
    test_branch();
    test_stall();
    test_flush_stall();
    test_invalid();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
